// File: rtl/unified_mem_arbiter_if.sv
// Memory-side handshake bundle for unified_mem_arbiter.
//   master : arbiter side  (drives m_valid/m_we/m_addr/m_wdata, samples m_rdata/m_ready)
//   slave  : memory side   (samples the request, drives m_rdata/m_ready)
// Signals:
//   m_valid  request valid          m_we    write enable
//   m_addr   address (AW)           m_wdata write data (DW)
//   m_rdata  read data (DW), valid when m_ready=1
//   m_ready  memory accepts/completes the access this cycle
interface unified_mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          m_valid;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ready;

   modport master (
      output m_valid, m_we, m_addr, m_wdata,
      input  m_rdata, m_ready
   );

   modport slave (
      input  m_valid, m_we, m_addr, m_wdata,
      output m_rdata, m_ready
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter for the single-port unified instruction/data memory shared by the
// IF and MEM stages. MEM has fixed priority (older instruction). One access
// at a time: grant -> wait for m_ready (bounded by TIMEOUT) -> one RESP cycle
// carrying registered done / bus_err pulses -> back to IDLE.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-low reset
//   if_req/if_addr       instruction fetch request; if_rdata/if_done result
//   mem_req/mem_we/...   data load/store request; mem_rdata/mem_done result
//   bus_err              pulse with the done pulse when the access timed out
//   pipe_stall           combinational pipeline hold
//   mbus                 memory handshake (master side)
module unified_mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15,
   parameter int TW      = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   input  logic          mem_req,
   input  logic          mem_we,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] mem_rdata,
   output logic          mem_done,
   output logic          bus_err,
   output logic          pipe_stall,
   unified_mem_arbiter_if.master mbus
);

   typedef enum logic [1:0] {IDLE, DATA, INST, RESP} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] cnt;
   logic          in_access;
   logic          timed_out;
   logic          finish;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mem_req)     state_nxt = DATA;
            else if (if_req) state_nxt = INST;
         end
         DATA, INST: if (finish) state_nxt = RESP;
         RESP:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Output decode: an access ends on m_ready or when the wait budget runs out
   always_comb begin
      in_access  = (state == DATA) || (state == INST);
      timed_out  = in_access && !mbus.m_ready && (cnt == TW'(TIMEOUT - 1));
      finish     = in_access && (mbus.m_ready || timed_out);
      pipe_stall = (if_req & ~if_done) | (mem_req & ~mem_done);
   end

   // Registered bus request, result data and one-cycle pulses
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt          <= '0;
         mbus.m_valid <= 1'b0;
         mbus.m_we    <= 1'b0;
         mbus.m_addr  <= '0;
         mbus.m_wdata <= '0;
         if_rdata     <= '0;
         mem_rdata    <= '0;
         if_done      <= 1'b0;
         mem_done     <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         if_done  <= 1'b0;
         mem_done <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_req) begin
                  mbus.m_valid <= 1'b1;
                  mbus.m_we    <= mem_we;
                  mbus.m_addr  <= mem_addr;
                  mbus.m_wdata <= mem_wdata;
                  cnt          <= '0;
               end else if (if_req) begin
                  mbus.m_valid <= 1'b1;
                  mbus.m_we    <= 1'b0;
                  mbus.m_addr  <= if_addr;
                  mbus.m_wdata <= '0;
                  cnt          <= '0;
               end
            end
            DATA, INST: begin
               if (finish) begin
                  mbus.m_valid <= 1'b0;
                  bus_err      <= timed_out;
                  if (state == DATA) begin
                     mem_done <= 1'b1;
                     if (timed_out)      mem_rdata <= '0;
                     else if (!mbus.m_we) mem_rdata <= mbus.m_rdata;
                  end else begin
                     if_done  <= 1'b1;
                     if_rdata <= timed_out ? '0 : mbus.m_rdata;
                  end
               end else begin
                  cnt <= cnt + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter. The bench plays the
// memory itself by driving m_ready/m_rdata cycle by cycle.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [31:0] if_rdata, mem_rdata;
   logic        if_done, mem_done, bus_err, pipe_stall;

   int unsigned tests = 0;
   int unsigned fails = 0;

   unified_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15), .TW(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_done    (if_done),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_done   (mem_done),
      .bus_err    (bus_err),
      .pipe_stall (pipe_stall),
      .mbus       (bus.master)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 2 ns after the edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      if_req = 0; mem_req = 0; mem_we = 0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0;
      bus.m_ready = 1'b0; bus.m_rdata = '0;

      // ---- reset state
      step(); step();
      chk("rst_m_valid", 32'(bus.m_valid), 0);
      chk("rst_m_addr",  bus.m_addr, 0);
      chk("rst_done",    {30'd0, if_done, mem_done}, 0);
      chk("rst_bus_err", 32'(bus_err), 0);
      reset = 1'b1;
      step();

      // ---- single fetch
      if_req = 1; if_addr = 32'h40;
      #1 chk("f_stall_idle", 32'(pipe_stall), 1);
      step();                                   // grant edge -> INST
      chk("f_m_valid", 32'(bus.m_valid), 1);
      chk("f_m_addr",  bus.m_addr, 32'h40);
      chk("f_m_we",    32'(bus.m_we), 0);
      chk("f_no_done", 32'(if_done), 0);
      bus.m_ready = 1; bus.m_rdata = 32'h8C220004;
      #1 chk("f_stall_inst", 32'(pipe_stall), 1);
      step();                                   // completion -> RESP
      chk("f_if_done",  32'(if_done), 1);
      chk("f_if_rdata", if_rdata, 32'h8C220004);
      chk("f_valid_lo", 32'(bus.m_valid), 0);
      chk("f_stall_rel", 32'(pipe_stall), 0);
      if_req = 0; bus.m_ready = 0;
      step();                                   // IDLE
      chk("f_pulse_end", 32'(if_done), 0);

      // ---- contention: MEM load wins, IF stays stalled
      if_req = 1; if_addr = 32'h44;
      mem_req = 1; mem_we = 0; mem_addr = 32'h100;
      step();                                   // DATA
      chk("c_m_addr_d", bus.m_addr, 32'h100);
      chk("c_m_we_d",   32'(bus.m_we), 0);
      bus.m_ready = 1; bus.m_rdata = 32'h11112222;
      step();                                   // RESP (data)
      chk("c_mem_done",  32'(mem_done), 1);
      chk("c_mem_rdata", mem_rdata, 32'h11112222);
      chk("c_if_wait",   32'(if_done), 0);
      chk("c_stall_resp", 32'(pipe_stall), 1);
      mem_req = 0; bus.m_ready = 0;
      step();                                   // IDLE
      chk("c_idle_valid", 32'(bus.m_valid), 0);
      chk("c_stall_idle", 32'(pipe_stall), 1);
      step();                                   // INST
      chk("c_m_addr_i", bus.m_addr, 32'h44);
      chk("c_stall_inst", 32'(pipe_stall), 1);
      bus.m_ready = 1; bus.m_rdata = 32'h33334444;
      step();                                   // RESP (inst)
      chk("c_if_done",  32'(if_done), 1);
      chk("c_if_rdata", if_rdata, 32'h33334444);
      chk("c_stall_rel", 32'(pipe_stall), 0);
      if_req = 0; bus.m_ready = 0;
      step();

      // ---- store with 5 wait states; requester inputs change mid-access
      mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
      step();                                   // DATA
      mem_addr = 32'h999; mem_wdata = 32'h0; mem_we = 0;
      for (int i = 0; i < 5; i++) begin
         chk("s_addr",  bus.m_addr, 32'h200);
         chk("s_wdata", bus.m_wdata, 32'hDEADBEEF);
         chk("s_we_valid", {30'd0, bus.m_we, bus.m_valid}, 32'h3);
         chk("s_no_done", 32'(mem_done), 0);
         step();
      end
      bus.m_ready = 1; bus.m_rdata = 32'hCAFEF00D;
      chk("s_addr_last", bus.m_addr, 32'h200);
      step();                                   // RESP
      chk("s_mem_done",  32'(mem_done), 1);
      chk("s_rdata_kept", mem_rdata, 32'h11112222);
      chk("s_no_err",    32'(bus_err), 0);
      mem_req = 0; bus.m_ready = 0;
      step();

      // ---- timeout: 15 wait cycles then abort
      mem_req = 1; mem_we = 0; mem_addr = 32'h300;
      step();                                   // DATA, cnt=0
      for (int i = 0; i < 15; i++) begin
         chk("t_valid_wait", 32'(bus.m_valid), 1);
         chk("t_no_done", 32'(mem_done), 0);
         step();
      end
      chk("t_valid_drop", 32'(bus.m_valid), 0);
      chk("t_mem_done",   32'(mem_done), 1);
      chk("t_bus_err",    32'(bus_err), 1);
      chk("t_rdata_zero", mem_rdata, 0);
      mem_req = 0;
      step();
      chk("t_err_pulse", {30'd0, bus_err, mem_done}, 0);
      mem_req = 1; mem_addr = 32'h304;
      step();
      chk("t2_m_addr", bus.m_addr, 32'h304);
      bus.m_ready = 1; bus.m_rdata = 32'h55AA55AA;
      step();
      chk("t2_done_err", {30'd0, mem_done, bus_err}, 32'h2);
      chk("t2_rdata", mem_rdata, 32'h55AA55AA);
      mem_req = 0; bus.m_ready = 0;
      step();

      // ---- reset mid-access
      if_req = 1; if_addr = 32'h80;
      step();                                   // INST
      chk("r_valid", 32'(bus.m_valid), 1);
      step();
      reset = 0;
      step();                                   // reset edge
      chk("r_valid_lo", 32'(bus.m_valid), 0);
      chk("r_no_done",  32'(if_done), 0);
      reset = 1;
      step();                                   // re-grant from IDLE
      chk("r_regrant_valid", 32'(bus.m_valid), 1);
      chk("r_regrant_addr",  bus.m_addr, 32'h80);
      bus.m_ready = 1; bus.m_rdata = 32'h12345678;
      step();
      chk("r_if_done",  32'(if_done), 1);
      chk("r_if_rdata", if_rdata, 32'h12345678);
      if_req = 0; bus.m_ready = 0;
      step();

      // ---- stale m_ready in IDLE
      bus.m_ready = 1; bus.m_rdata = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_valid", 32'(bus.m_valid), 0);
         chk("st_done",  {30'd0, if_done, mem_done}, 0);
         chk("st_stall", 32'(pipe_stall), 0);
      end
      chk("st_if_rdata", if_rdata, 32'h12345678);
      bus.m_ready = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
